fetch_stage: RTL and testbench

Instruction-fetch front end of the forwarding pipeline. It owns the PC, issues one-at-a-time read requests to the instruction SRAM, and buffers returned words in a 2-entry queue. Each queued word, with its PC, is presented to the decode stage, whose control unit consumes the instruction. It honours decode back-pressure (`stall_id`) and branch/jump redirects from execute, killing in-flight and queued fetches.

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one outstanding SRAM read at a
// time and buffers returned words with their PCs in a 2-entry queue for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic        o_insn_vld,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       req_pc_q;
  entry_t [1:0]      fifo_q;
  logic              rd_q;
  logic [1:0]        count_q;

  entry_t            head;
  logic              pop;
  logic              accept;
  logic              issue;
  logic              wr_idx;
  logic [1:0]        count_d;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    head       = fifo_q[rd_q];
    o_insn_vld = (count_q != 2'd0) && !redirect_vld;
    o_instr    = (count_q != 2'd0) ? head.instr : 32'h0;
    o_pc       = (count_q != 2'd0) ? head.pc    : 32'h0;
    pop        = o_insn_vld && !stall_id;
    accept     = imem_rvalid && (state_q == WAIT) && !redirect_vld;
    // Occupancy never exceeds 2: a request is only issued when a slot is
    // guaranteed for its response.
    count_d    = count_q + {1'b0, accept} - {1'b0, pop};
    issue      = ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid)) &&
                 (count_d < 2'd2) && !redirect_vld;
    imem_req   = issue && !i_reset;
    imem_addr  = pc_q;
    // With two entries the write slot is the head when full (pop frees it).
    wr_idx     = rd_q ^ count_q[0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      fifo_q   <= '0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect_vld) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      pc_q    <= {redirect_pc[31:2], 2'b00};
      // A request still in flight must have its response swallowed.
      case (state_q)
        WAIT:    state_q <= imem_rvalid ? IDLE : DISCARD;
        DISCARD: state_q <= imem_rvalid ? IDLE : DISCARD;
        default: state_q <= IDLE;
      endcase
    end else begin
      if (accept) fifo_q[wr_idx] <= '{pc: req_pc_q, instr: imem_rdata};
      if (pop) rd_q <= ~rd_q;
      count_q <= count_d;
      if (issue) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
        state_q  <= WAIT;
      end else if ((state_q != IDLE) && imem_rvalid) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: an SRAM model with random latency, a
// sequential-stream reference of delivered PCs, and directed corner scenarios.
module tb_fetch_stage;

  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst, rvalid, redir, stall;
  logic [31:0] rdata, redir_pc;
  logic        req, vld, req2, vld2;
  logic [31:0] addr, instr, pc, addr2, instr2, pc2;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_reset(rst), .imem_req(req), .imem_addr(addr),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .redirect_vld(redir),
    .redirect_pc(redir_pc), .stall_id(stall), .o_insn_vld(vld),
    .o_instr(instr), .o_pc(pc));

  fetch_stage #(.RESET_PC(RPC2)) dut2 (
    .i_clk(clk), .i_reset(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .redirect_vld(redir),
    .redirect_pc(redir_pc), .stall_id(stall), .o_insn_vld(vld2),
    .o_instr(instr2), .o_pc(pc2));

  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] stream_next, req_next;
  bit          pend;
  int          pend_lat;
  logic [31:0] pend_addr;
  int          lat_min = 1, lat_max = 1;
  int          idle_cyc = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input bit act, input bit exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(stream_next);
      stream_next += 32'd4;
    end
  endtask

  // Fetch restarts (reset / redirect): the delivered stream becomes target, +4, +8 ...
  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    stream_next = a;
    req_next    = a;
    top_up();
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit rs, input bit stray);
    @(posedge clk);
    #1;
    rst = rs; stall = st; redir = rd; redir_pc = rpc;
    rvalid = 1'b0; rdata = 32'h0;
    if (rs) begin
      pend = 1'b0;
      restart(32'h0);
    end else begin
      if (pend) begin
        pend_lat--;
        if (pend_lat == 0) begin
          rvalid = 1'b1;
          rdata  = word_at(pend_addr);
          pend   = 1'b0;
        end
      end
      if (stray) begin
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
      end
      if (rd) restart({rpc[31:2], 2'b00});
    end
    top_up();
    #3;
  endtask

  // Monitor: checks every request and every delivered instruction mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chkb("rst_req", req, 1'b0);
      chkb("rst_vld", vld, 1'b0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chkb("rst_req2", req2, 1'b0);
      chkb("rst_vld2", vld2, 1'b0);
      idle_cyc = 0;
    end else begin
      if (redir) begin
        chkb("redir_vld", vld, 1'b0);
        chkb("redir_req", req, 1'b0);
      end
      if (req) begin
        chk("req_addr", addr, req_next);
        chkb("one_outstanding", pend, 1'b0);
        req_next  += 32'd4;
        pend      = 1'b1;
        pend_lat  = $urandom_range(lat_max, lat_min);
        pend_addr = addr;
      end
      if (vld && !stall) begin
        if (exp_q.size() == 0) chkb("stream_empty", 1'b1, 1'b0);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("o_pc", pc, e);
          chk("o_instr", instr, word_at(e));
        end
        idle_cyc = 0;
      end else if (stall || redir) idle_cyc = 0;
      else idle_cyc++;
      chkb("progress", idle_cyc <= 15, 1'b1);
    end
  end

  initial begin
    logic [31:0] held;
    int k;
    rst = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    rvalid = 1'b0; rdata = 32'h0; pend = 1'b0; pend_lat = 0; pend_addr = 32'h0;
    restart(32'h0);
    #1 rst = 1'b1;
    repeat (3) step(0, 0, 0, 1, 0);

    // Start-up and full throughput with a 1-cycle SRAM
    lat_min = 1; lat_max = 1;
    step(0, 0, 0, 0, 0);
    chkb("c0_req", req, 1'b1); chkb("c0_vld", vld, 1'b0);
    chk("c0_addr2", addr2, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0);
    chkb("c1_req", req, 1'b1); chkb("c1_vld", vld, 1'b0);
    chk("c1_addr2", addr2, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chkb("c2_req", req, 1'b1); chkb("c2_vld", vld, 1'b1);
    chk("c2_addr2", addr2, 32'h0000_0000);
    chk("c2_pc2", pc2, 32'hFFFF_FFF8);
    repeat (8) begin
      step(0, 0, 0, 0, 0);
      chkb("thru_vld", vld, 1'b1);
      chkb("thru_req", req, 1'b1);
    end

    // Decode stall: queue fills, fetch pauses, head stays put
    step(1, 0, 0, 0, 0);
    held = instr;
    chkb("stall0_vld", vld, 1'b1);
    repeat (3) begin
      step(1, 0, 0, 0, 0);
      chkb("stall_req", req, 1'b0);
      chk("stall_instr", instr, held);
    end
    repeat (8) step(0, 0, 0, 0, 0);

    // Redirect while a 3-cycle response is still outstanding
    lat_min = 3; lat_max = 3;
    k = 0;
    while (!(pend && pend_lat >= 2) && k < 30) begin step(0, 0, 0, 0, 0); k++; end
    chkb("rd_wait_found", pend && pend_lat >= 2, 1'b1);
    step(0, 1, 32'h0000_0103, 0, 0);
    chkb("rd_cycle_vld", vld, 1'b0);
    k = 0;
    while (!req && k < 10) begin step(0, 0, 0, 0, 0); k++; end
    chkb("rd_req_seen", req, 1'b1);
    chk("rd_first_addr", addr, 32'h0000_0100);
    chkb("rd_req_latency", k <= 3, 1'b1);
    k = 0;
    while (!vld && k < 10) begin step(0, 0, 0, 0, 0); k++; end
    chk("rd_first_pc", pc, 32'h0000_0100);
    repeat (6) step(0, 0, 0, 0, 0);

    // Redirect coinciding with a response: the word is dropped
    lat_min = 2; lat_max = 2;
    k = 0;
    while (!(pend && pend_lat == 1) && k < 30) begin step(0, 0, 0, 0, 0); k++; end
    chkb("rdv_found", pend && pend_lat == 1, 1'b1);
    step(0, 1, 32'h0000_2000, 0, 0);
    chkb("rdv_vld", vld, 1'b0);
    step(0, 0, 0, 0, 0);
    chkb("rdv_next_req", req, 1'b1);
    chk("rdv_next_addr", addr, 32'h0000_2000);
    repeat (8) step(0, 0, 0, 0, 0);

    // Address wrap past the top of memory
    lat_min = 1; lat_max = 1;
    step(0, 1, 32'hFFFF_FFF9, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);

    // Reset during WAIT, then a stray response from the killed request
    lat_min = 3; lat_max = 3;
    k = 0;
    while (!pend && k < 20) begin step(0, 0, 0, 0, 0); k++; end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chkb("rst_stray_req", req, 1'b1);
    chk("rst_stray_addr", addr, 32'h0000_0000);
    repeat (12) step(0, 0, 0, 0, 0);

    // Randomized traffic
    lat_min = 1; lat_max = 3;
    repeat (2000) begin
      int r;
      bit st, rd, rs;
      logic [31:0] rpc;
      r   = $urandom_range(99, 0);
      rs  = (r < 1);
      rd  = (r >= 1) && (r < 6);
      st  = ($urandom_range(3, 0) == 0);
      rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFF);
      step(st, rd, rpc, rs, 1'b0);
    end
    repeat (20) step(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
